aes_key_mem: RTL
================

// Module: aes_key_mem
// PURPOSE
// Key expansion and round-key store upstream of AES_encipher. On init, expands the cipher
// key into all round keys, one 128-bit round key per cycle, into a register file.
// Then serves round_key combinationally for the round index driven by the encipher
// (its `round` output). Supports AES-128 (11 keys) and AES-256 (15 keys).
// PARAMETERS
// (none) round-key counts are fixed: AES-128 = 10 rounds, AES-256 = 14 rounds
// PORTS
// clk        in   1    clock; all state updates on rising edge
// rst        in   1    synchronous reset, active-high
// init       in   1    start expansion; single-cycle pulse, sampled on clk rising edge
// keylen     in   1    0 = AES-128, 1 = AES-256; sampled only when init is accepted
// key        in   256  cipher key; AES-128 uses key[255:128]; held stable only in the init cycle
// round      in   4    round-key index requested by encipher
// round_key  out  128  key_mem[round]; 128'h0 if round > last round of latched keylen
// ready      out  1    1 = all round keys valid; cleared by init
// BEHAVIOUR
// - Reset (rst=1 at edge): state=IDLE, ready=0, all 15 key_mem entries=0, counter=0, rcon=8'h01.
//   round_key therefore reads 0.
// - FSM:
//   IDLE --init--> INIT -> GEN -> (last key written) -> IDLE.
//   init in INIT/GEN restarts expansion: go to INIT, ready=0.
//   init in IDLE also clears ready.
// - Init acceptance: key, keylen and init are sampled at accept edge E0.
//   key_r and keylen_r are latched at E0, so key need not be held after E0.
// - INIT (edge E1):
//   AES-128: key_mem[0]=key_r[255:128]; cnt=1.
//   AES-256: key_mem[0]=key_r[255:128], key_mem[1]=key_r[127:0]; cnt=2.
//   rcon=8'h01.
// - GEN (one key per edge): write key_mem[cnt]; cnt++.
//   prev = key_mem[cnt-1] = {w0,w1,w2,w3}; for AES-256, pp = key_mem[cnt-2].
//   AES-128:
//     t=SubWord(RotWord(w3))^{rcon,24'h0}
//     n0=prev.w0^t; n1=w1^n0; n2=w2^n1; n3=w3^n2
//     rcon advances after every key
//   AES-256, cnt even:
//     t=SubWord(RotWord(w3))^{rcon,24'h0}; XOR chain starts from pp.w0
//     rcon advances
//   AES-256, cnt odd:
//     t=SubWord(w3), no rotate, no rcon; XOR chain from pp.w0
// - RotWord = {b1,b2,b3,b0}. SubWord uses constant.sbox per byte (4 lookups/cycle).
// - rcon update: xtime in GF(2^8): rcon<<1, XOR 8'h1b when bit7 was set.
//   Sequence: 01 02 04 08 10 20 40 80 1b 36.
// - Completion:
//   key 10 (AES-128) or key 14 (AES-256) is written on the same edge that sets ready=1
//   and state=IDLE.
//   Latency from accept edge E0: ready high after E11 (AES-128) or E14 (AES-256).
// - round_key is combinational from round and key_mem; no added latency.
//   Reads during GEN return partially updated contents; the consumer waits for ready.
// - Index guard: round > 10 (AES-128) or round > 14 (AES-256) returns 128'h0.
//   round = 15 always returns 0.
// - keylen changes after acceptance have no effect until the next init.
// - rst mid-expansion: the next edge forces the full reset state; the partial
//   expansion is discarded.
// - Simultaneous rst and init: rst wins.
// TESTING
// - Reset: rst=1 for 2 cycles -> ready=0, round_key=0 for round=0..15.
// - AES-128 FIPS-197 A.1: init, keylen=0, key[255:128]=2b7e151628aed2a6abf7158809cf4f3c
//   -> ready rises after E11.
//   round=1 -> a0fafe1788542cb123a339392a6c7605.
//   round=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
//   round=11 -> 0.
// - AES-256 FIPS-197 A.3: key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4
//   -> ready after E14.
//   round=1 -> 1f352c073b6108d72d9810a30914dff4.
//   round=14 -> fe4890d1e6188d0b046df344706c631e.
// - Restart: init AES-128, re-pulse init with AES-256 key at E5
//   -> ready stays 0; AES-256 keys are correct after 14 more edges.
// - Reset mid-run: rst at E6 of AES-128 expansion -> ready=0, all round_key=0;
//   a fresh init then completes correctly.
// - Key hold: change key and keylen to garbage after E0
//   -> the expansion result still matches the A.1 vector.

Source files
------------

// File: rtl/aes_key_mem.sv
// AES key expansion and round-key register file. Expands an AES-128 or AES-256 key
// at one 128-bit round key per cycle and serves the key for `round` combinationally.
module aes_key_mem (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         keylen,
  input  logic [255:0] key,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready
);

  typedef enum logic [1:0] {IDLE, INIT, GEN} state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  state_t         state, state_nxt;
  logic [127:0]   key_mem [15];
  logic [255:0]   key_r;
  logic           keylen_r;
  logic [3:0]     cnt;
  logic [7:0]     rcon;

  logic [127:0]   prev, pp, new_key;
  logic [31:0]    w3, sub_in, t;
  logic [31:0]    n0, n1, n2, n3;
  logic           use_rcon, last_key;
  logic [3:0]     last_round;

  // Expansion datapath: prev is the key just written, pp the one before it (AES-256).
  always_comb begin
    prev     = key_mem[cnt - 4'd1];
    pp       = keylen_r ? key_mem[cnt - 4'd2] : prev;
    w3       = prev[31:0];
    use_rcon = !keylen_r || !cnt[0];
    sub_in   = use_rcon ? {w3[23:0], w3[31:24]} : w3;
    t        = sub_word(sub_in) ^ (use_rcon ? {rcon, 24'h0} : 32'h0);
    n0       = pp[127:96] ^ t;
    n1       = pp[95:64]  ^ n0;
    n2       = pp[63:32]  ^ n1;
    n3       = pp[31:0]   ^ n2;
    new_key  = {n0, n1, n2, n3};
    last_key = keylen_r ? (cnt == 4'd14) : (cnt == 4'd10);
  end

  // init from any state (re)starts expansion.
  always_comb begin
    state_nxt = state;
    if (init) begin
      state_nxt = INIT;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        INIT:    state_nxt = GEN;
        GEN:     if (last_key) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: key_r is pure datapath consumed only after an accepted init, so it carries no reset.
  always_ff @(posedge clk) begin
    if (init) key_r <= key;
  end

  // NOTE: key_mem is reset entry by entry because unused round keys must read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ready    <= 1'b0;
      cnt      <= 4'd0;
      rcon     <= 8'h01;
      keylen_r <= 1'b0;
      for (int i = 0; i < 15; i++) key_mem[i] <= '0;
    end else begin
      state <= state_nxt;
      if (init) begin
        keylen_r <= keylen;
        ready    <= 1'b0;
      end else begin
        case (state)
          INIT: begin
            key_mem[0] <= key_r[255:128];
            if (keylen_r) begin
              key_mem[1] <= key_r[127:0];
              cnt        <= 4'd2;
            end else begin
              cnt        <= 4'd1;
            end
            rcon <= 8'h01;
          end
          GEN: begin
            key_mem[cnt] <= new_key;
            cnt          <= cnt + 4'd1;
            if (use_rcon) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            if (last_key) ready <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign last_round = keylen_r ? 4'd14 : 4'd10;
  assign round_key  = (round > last_round) ? 128'h0 : key_mem[round];

endmodule
